// File: rtl/sbox6_serial_layer.sv
// sbox6_serial_layer
// Serial substitution layer. A block of NWORDS 6-bit words passes through
// one shared external combinational S-box, one word per clock. The block
// is held in a shift register. Each RUN cycle presents the lowest word to
// the S-box and inserts the S-box result at the top. After NWORDS shifts,
// every word is back in its original position, now substituted.
// The S-box path is a single cycle: dreg[5:0] -> sbox_y -> top word of dreg.

module sbox6_serial_layer #(
    parameter int NWORDS = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [6*NWORDS-1:0]   in_data,
    output logic [5:0]            sbox_x,
    input  logic [5:0]            sbox_y,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [6*NWORDS-1:0]   out_data
);

    localparam int W  = 6 * NWORDS;
    localparam int CW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NWORDS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    r_state;
    logic [W-1:0]  r_dreg;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  w_shifted;

    // Next dreg value during RUN: shift right one word, with the S-box result entering at the top
    generate
        if (NWORDS == 1) begin : g_single
            assign w_shifted = sbox_y;
        end else begin : g_multi
            assign w_shifted = {sbox_y, r_dreg[W-1:6]};
        end
    endgenerate

    // Control FSM: accept in IDLE, shift NWORDS times in RUN, hold the result in DONE until taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_dreg  <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_dreg  <= in_data;
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_dreg <= w_shifted;
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Handshake outputs depend on state only, so out_ready never reaches in_ready combinationally
    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign out_data  = r_dreg;

    // The S-box input is parked at zero outside RUN so the external S-box does not toggle
    assign sbox_x = (r_state == S_RUN) ? r_dreg[5:0] : 6'h00;

endmodule

// File: tb/tb_sbox6_serial_layer.sv
// tb_sbox6_serial_layer
// Self-checking bench. The external S-box is modelled as x ^ 6'h3F.
// Expected blocks come from a word-by-word reference substitution.
// A second instance with NWORDS=1 covers the single-word build.

module tb_sbox6_serial_layer;

    localparam int N  = 6;
    localparam int W  = 6 * N;

    typedef struct {
        logic [W-1:0] din;
        logic [W-1:0] dout;
    } vec_t;

    logic         clk;
    logic         rst;
    logic         inValid;
    logic         inReady;
    logic [W-1:0] inData;
    logic [5:0]   sboxX;
    logic [5:0]   sboxY;
    logic         outValid;
    logic         outReady;
    logic [W-1:0] outData;

    logic         inValid1;
    logic         inReady1;
    logic [5:0]   inData1;
    logic [5:0]   sboxX1;
    logic [5:0]   sboxY1;
    logic         outValid1;
    logic         outReady1;
    logic [5:0]   outData1;

    int nTests;
    int nFail;

    vec_t vecs [4];

    sbox6_serial_layer #(.NWORDS(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .in_data   (inData),
        .sbox_x    (sboxX),
        .sbox_y    (sboxY),
        .out_valid (outValid),
        .out_ready (outReady),
        .out_data  (outData)
    );

    sbox6_serial_layer #(.NWORDS(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (inValid1),
        .in_ready  (inReady1),
        .in_data   (inData1),
        .sbox_x    (sboxX1),
        .sbox_y    (sboxY1),
        .out_valid (outValid1),
        .out_ready (outReady1),
        .out_data  (outData1)
    );

    // External combinational S-box models
    assign sboxY  = sboxX ^ 6'h3F;
    assign sboxY1 = sboxX1 ^ 6'h3F;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] sModel(input logic [5:0] x);
        return x ^ 6'h3F;
    endfunction

    function automatic logic [W-1:0] refBlock(input logic [W-1:0] d);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            r[6*i +: 6] = sModel(d[6*i +: 6]);
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full transaction on the NWORDS=6 instance with junk on the input side while busy
    task automatic applyStimulus(input logic [W-1:0] din, input logic [W-1:0] expd, input int stall);
        checkOutput("idle in_ready", 64'(inReady), 64'd1);
        inValid  = 1'b1;
        inData   = din;
        outReady = 1'b0;
        step();
        for (int k = 0; k < N; k++) begin
            inValid = 1'($urandom);
            inData  = {$urandom, $urandom};
            checkOutput("run sbox_x", 64'(sboxX), 64'(din[6*k +: 6]));
            checkOutput("run in_ready", 64'(inReady), 64'd0);
            checkOutput("run out_valid", 64'(outValid), 64'd0);
            step();
        end
        checkOutput("done out_valid", 64'(outValid), 64'd1);
        checkOutput("done out_data", 64'(outData), 64'(expd));
        for (int s = 0; s < stall; s++) begin
            inValid = 1'($urandom);
            inData  = {$urandom, $urandom};
            step();
            checkOutput("stall out_valid", 64'(outValid), 64'd1);
            checkOutput("stall out_data", 64'(outData), 64'(expd));
            checkOutput("stall in_ready", 64'(inReady), 64'd0);
            checkOutput("stall sbox_x", 64'(sboxX), 64'd0);
        end
        outReady = 1'b1;
        step();
        outReady = 1'b0;
        inValid  = 1'b0;
        checkOutput("release out_valid", 64'(outValid), 64'd0);
        checkOutput("release in_ready", 64'(inReady), 64'd1);
    endtask

    initial begin
        logic [W-1:0] rd;
        logic [W-1:0] gotQ [$];
        int acc [$];

        nTests    = 0;
        nFail     = 0;
        rst       = 1'b1;
        inValid   = 1'b0;
        inData    = '0;
        outReady  = 1'b0;
        inValid1  = 1'b0;
        inData1   = '0;
        outReady1 = 1'b0;

        vecs[0] = '{din: 36'h1440C2040, dout: 36'hEBBF3DFBF};
        vecs[1] = '{din: 36'h000000000, dout: 36'hFFFFFFFFF};
        vecs[2] = '{din: 36'hFFFFFFFFF, dout: 36'h000000000};
        vecs[3] = '{din: 36'h123456789, dout: 36'hEDCBA9876};

        #12;
        checkOutput("reset in_ready", 64'(inReady), 64'd1);
        checkOutput("reset out_valid", 64'(outValid), 64'd0);
        checkOutput("reset out_data", 64'(outData), 64'd0);
        checkOutput("reset sbox_x", 64'(sboxX), 64'd0);
        rst = 1'b0;
        step();

        for (int v = 0; v < 4; v++) begin
            applyStimulus(vecs[v].din, vecs[v].dout, 0);
        end

        applyStimulus(36'h1440C2040, 36'hEBBF3DFBF, 10);

        // Back-to-back with in_valid held high and out_ready high
        inValid  = 1'b1;
        inData   = 36'h1440C2040;
        outReady = 1'b1;
        for (int c = 0; c < 40 && gotQ.size() < 2; c++) begin
            if (inReady && inValid) acc.push_back(c);
            if (outValid) gotQ.push_back(outData);
            step();
            if (acc.size() == 1) inData = 36'h000000000;
            if (acc.size() == 2) inValid = 1'b0;
        end
        inValid  = 1'b0;
        outReady = 1'b0;
        checkOutput("b2b accept count", 64'(acc.size()), 64'd2);
        checkOutput("b2b result count", 64'(gotQ.size()), 64'd2);
        if (acc.size() == 2) checkOutput("b2b spacing", 64'(acc[1] - acc[0]), 64'd8);
        if (gotQ.size() == 2) begin
            checkOutput("b2b first data", 64'(gotQ[0]), 64'h0EBBF3DFBF);
            checkOutput("b2b second data", 64'(gotQ[1]), 64'h0FFFFFFFFF);
        end
        step();
        step();

        // Reset in the middle of RUN
        checkOutput("pre-reset in_ready", 64'(inReady), 64'd1);
        inValid = 1'b1;
        inData  = 36'h1440C2040;
        step();
        inValid = 1'b0;
        step();
        step();
        step();
        checkOutput("mid-run sbox_x", 64'(sboxX), 64'h03);
        #2 rst = 1'b1;
        #1;
        checkOutput("async rst in_ready", 64'(inReady), 64'd1);
        checkOutput("async rst out_valid", 64'(outValid), 64'd0);
        checkOutput("async rst sbox_x", 64'(sboxX), 64'd0);
        checkOutput("async rst out_data", 64'(outData), 64'd0);
        step();
        rst = 1'b0;
        step();
        applyStimulus(36'hABCDEF012, refBlock(36'hABCDEF012), 1);

        // Randomized blocks against the reference substitution
        for (int r = 0; r < 20; r++) begin
            rd = {$urandom, $urandom};
            applyStimulus(rd, refBlock(rd), int'($urandom_range(0, 4)));
        end

        // Single-word build
        checkOutput("n1 in_ready", 64'(inReady1), 64'd1);
        inValid1 = 1'b1;
        inData1  = 6'h15;
        step();
        inValid1 = 1'b0;
        inData1  = 6'h3F;
        checkOutput("n1 sbox_x", 64'(sboxX1), 64'h15);
        checkOutput("n1 in_ready busy", 64'(inReady1), 64'd0);
        step();
        checkOutput("n1 out_valid", 64'(outValid1), 64'd1);
        checkOutput("n1 out_data", 64'(outData1), 64'h2A);
        outReady1 = 1'b1;
        step();
        outReady1 = 1'b0;
        checkOutput("n1 release", 64'(outValid1), 64'd0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
